// File: rtl/turbo_encoder_param_if.sv
// Stream interface of the turbo encoder: serial bit input side and
// coded-symbol output side, each with valid/ready flow control.
// The slave modport is the encoder; the master modport is its environment
// (bit source on the input side, serializer on the output side).
interface turbo_encoder_param_if;
    logic       punct;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out_sym;
    logic [2:0] out_mask;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output punct, in_bit, in_valid, out_ready,
        input  in_ready, out_sym, out_mask, out_valid, out_last
    );

    modport slave (
        input  punct, in_bit, in_valid, out_ready,
        output in_ready, out_sym, out_mask, out_valid, out_last
    );
endinterface

// File: rtl/turbo_encoder_param.sv
// Parametrised turbo encoder: a K-bit block is captured serially, then
// encoded by two RSC encoders (natural order and QPP-interleaved order)
// followed by M tail steps for each encoder. One symbol per output handshake.
// M must be at least 2 (shift register update uses s[M-1:1]).
module turbo_encoder_param #(
    parameter int         K    = 40,
    parameter int         M    = 3,
    parameter logic [M:0] G_FB = 4'b1011,
    parameter logic [M:0] G_FF = 4'b1101,
    parameter int         F1   = 3,
    parameter int         F2   = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    turbo_encoder_param_if.slave bus
);
    localparam int            CW        = $clog2(K);
    localparam int            CW1       = CW + 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(K - 1);
    localparam logic [CW-1:0] LAST_TAIL = CW'(M - 1);
    localparam logic [CW:0]   K_EXT     = CW1'(K);
    localparam logic [CW-1:0] G_INIT    = CW'((F1 + F2) % K);
    localparam logic [CW-1:0] G_INC     = CW'((2 * F2) % K);

    typedef enum logic [2:0] {IDLE, LOAD, ENCODE, TERM1, TERM2, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;       // load write pointer
    logic [CW-1:0] step_q, step_d;     // data step i, or tail step
    logic [CW-1:0] pi_q, pi_d;         // pi(i)
    logic [CW-1:0] g_q, g_d;           // increment g(i) of pi
    logic          punct_q, punct_d;
    logic [M-1:0]  s1_q, s1_d;         // bit j-1 holds s[j] of encoder 1
    logic [M-1:0]  s2_q, s2_d;
    logic          in_ready_q, in_ready_d;
    logic [2:0]    out_sym_q, out_sym_d;
    logic [2:0]    out_mask_q, out_mask_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;

    logic          buf_mem [K];

    logic          in_accept, advance;
    logic          u1, u2, fb1, fb2, ff1, ff2, a1, a2, z1, z2;
    logic [CW:0]   pi_sum, g_sum;
    logic [CW-1:0] pi_next, g_next;

    assign in_accept = bus.in_valid & in_ready_q;
    // A new symbol may be produced when the output register is empty or draining.
    assign advance   = ~out_valid_q | bus.out_ready;

    assign u1  = buf_mem[step_q];
    assign u2  = buf_mem[pi_q];
    assign fb1 = ^(s1_q & G_FB[M:1]);
    assign fb2 = ^(s2_q & G_FB[M:1]);
    assign ff1 = ^(s1_q & G_FF[M:1]);
    assign ff2 = ^(s2_q & G_FF[M:1]);
    assign a1  = u1 ^ fb1;
    assign a2  = u2 ^ fb2;
    assign z1  = (a1 & G_FF[0]) ^ ff1;
    assign z2  = (a2 & G_FF[0]) ^ ff2;

    // Interleaver address recurrence: both operands are < K, so one
    // conditional subtract is enough to stay in range.
    assign pi_sum  = {1'b0, pi_q} + {1'b0, g_q};
    assign g_sum   = {1'b0, g_q} + {1'b0, G_INC};
    assign pi_next = (pi_sum >= K_EXT) ? CW'(pi_sum - K_EXT) : CW'(pi_sum);
    assign g_next  = (g_sum >= K_EXT) ? CW'(g_sum - K_EXT) : CW'(g_sum);

    // Block buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (in_accept) begin
            buf_mem[idx_q] <= bus.in_bit;
        end
    end

    // State register with asynchronous abort of any block in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            step_q      <= '0;
            pi_q        <= '0;
            g_q         <= '0;
            punct_q     <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            in_ready_q  <= 1'b0;
            out_sym_q   <= '0;
            out_mask_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            step_q      <= step_d;
            pi_q        <= pi_d;
            g_q         <= g_d;
            punct_q     <= punct_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            in_ready_q  <= in_ready_d;
            out_sym_q   <= out_sym_d;
            out_mask_q  <= out_mask_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next-state and datapath: load, encode, terminate, wait for last handshake.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        step_d      = step_q;
        pi_d        = pi_q;
        g_d         = g_q;
        punct_d     = punct_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        in_ready_d  = in_ready_q;
        out_sym_d   = out_sym_q;
        out_mask_d  = out_mask_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE, LOAD: begin
                in_ready_d = 1'b1;
                if (in_accept) begin
                    if (state_q == IDLE) begin
                        punct_d = bus.punct;
                    end
                    state_d = LOAD;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d    = ENCODE;
                        in_ready_d = 1'b0;
                        idx_d      = '0;
                        step_d     = '0;
                        pi_d       = '0;
                        g_d        = G_INIT;
                        s1_d       = '0;
                        s2_d       = '0;
                    end
                end
            end
            ENCODE: begin
                if (advance) begin
                    out_sym_d   = {z2, z1, u1};
                    out_mask_d  = punct_q ? (step_q[0] ? 3'b101 : 3'b011) : 3'b111;
                    out_valid_d = 1'b1;
                    s1_d        = {s1_q[M-2:0], a1};
                    s2_d        = {s2_q[M-2:0], a2};
                    pi_d        = pi_next;
                    g_d         = g_next;
                    step_d      = step_q + 1'b1;
                    if (step_q == LAST_IDX) begin
                        state_d = TERM1;
                        step_d  = '0;
                    end
                end
            end
            TERM1: begin
                // Feeding the feedback sum back in forces a = 0 and flushes s1.
                if (advance) begin
                    out_sym_d   = {1'b0, ff1, fb1};
                    out_mask_d  = 3'b011;
                    out_valid_d = 1'b1;
                    s1_d        = {s1_q[M-2:0], 1'b0};
                    step_d      = step_q + 1'b1;
                    if (step_q == LAST_TAIL) begin
                        state_d = TERM2;
                        step_d  = '0;
                    end
                end
            end
            TERM2: begin
                if (advance) begin
                    out_sym_d   = {ff2, 1'b0, fb2};
                    out_mask_d  = 3'b101;
                    out_valid_d = 1'b1;
                    s2_d        = {s2_q[M-2:0], 1'b0};
                    step_d      = step_q + 1'b1;
                    if (step_q == LAST_TAIL) begin
                        state_d    = DONE;
                        out_last_d = 1'b1;
                        step_d     = '0;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_mask  = out_mask_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_turbo_encoder_param.sv
// Bench for turbo_encoder_param: directed and random blocks compared to a
// reference model built from the closed-form interleaver and RSC equations.
module tb_turbo_encoder_param;
    localparam int         K    = 40;
    localparam int         M    = 3;
    localparam logic [M:0] G_FB = 4'b1011;
    localparam logic [M:0] G_FF = 4'b1101;
    localparam int         F1   = 3;
    localparam int         F2   = 10;
    localparam int         NSYM = K + 2 * M;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    turbo_encoder_param_if bus();

    turbo_encoder_param #(
        .K(K), .M(M), .G_FB(G_FB), .G_FF(G_FF), .F1(F1), .F2(F2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    bit         blk      [K];
    logic [2:0] exp_sym  [NSYM];
    logic [2:0] exp_mask [NSYM];
    logic       exp_last [NSYM];
    logic [2:0] got_sym  [NSYM];
    logic [2:0] ref_sym  [NSYM];
    int         st       [2][M+1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int fb_sum(input int e);
        int r = 0;
        for (int j = 1; j <= M; j++) r ^= st[e][j] & int'(G_FB[j]);
        return r;
    endfunction

    function automatic int parity(input int e, input int a);
        int r = a & int'(G_FF[0]);
        for (int j = 1; j <= M; j++) r ^= st[e][j] & int'(G_FF[j]);
        return r;
    endfunction

    function automatic void push(input int e, input int a);
        for (int j = M; j > 1; j--) st[e][j] = st[e][j-1];
        st[e][1] = a;
    endfunction

    // Expected symbol stream of the whole block.
    function automatic void build_model(input bit p);
        int u1, u2, a1, a2, z1, z2, pidx, u, z;
        for (int e = 0; e < 2; e++)
            for (int j = 0; j <= M; j++) st[e][j] = 0;
        for (int i = 0; i < K; i++) begin
            pidx = (F1 * i + F2 * i * i) % K;
            u1 = int'(blk[i]);
            u2 = int'(blk[pidx]);
            a1 = u1 ^ fb_sum(0);
            a2 = u2 ^ fb_sum(1);
            z1 = parity(0, a1);
            z2 = parity(1, a2);
            exp_sym[i]  = 3'(z2 * 4 + z1 * 2 + u1);
            exp_mask[i] = !p ? 3'b111 : ((i % 2 == 0) ? 3'b011 : 3'b101);
            exp_last[i] = 1'b0;
            push(0, a1);
            push(1, a2);
        end
        for (int t = 0; t < M; t++) begin
            u = fb_sum(0);
            z = parity(0, 0);
            exp_sym[K+t]  = 3'(z * 2 + u);
            exp_mask[K+t] = 3'b011;
            exp_last[K+t] = 1'b0;
            push(0, 0);
        end
        for (int t = 0; t < M; t++) begin
            u = fb_sum(1);
            z = parity(1, 0);
            exp_sym[K+M+t]  = 3'(z * 4 + u);
            exp_mask[K+M+t] = 3'b101;
            exp_last[K+M+t] = (t == M - 1);
            push(1, 0);
        end
    endfunction

    task automatic load_block(input bit p);
        int i = 0;
        int guard = 0;
        bit hs;
        while (i < K) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_bit   = blk[i];
            bus.punct    = (i == 0) ? p : 1'($urandom_range(0, 1));
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (hs) i++;
            guard++;
            if (guard > 1000) begin
                check("load_timeout", i, K);
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        check("in_ready_drop", bus.in_ready, 0);
        $display("loaded block punct=%0d", p);
    endtask

    task automatic collect(input int rdy_pct, input int abort_at);
        int n = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [2:0] hold_sym = 3'b0;
        logic [2:0] hold_mask = 3'b0;
        while (n < NSYM) begin
            if (abort_at >= 0 && n == abort_at) begin
                reset = 1'b1;
                #1;
                check("rst_out_valid", bus.out_valid, 0);
                check("rst_out_sym", bus.out_sym, 0);
                check("rst_out_mask", bus.out_mask, 0);
                check("rst_out_last", bus.out_last, 0);
                check("rst_in_ready", bus.in_ready, 0);
                $display("reset asserted after symbol %0d", n);
                return;
            end
            bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
            @(negedge clk);
            if (bus.out_valid) begin
                if (stalled) begin
                    check("stall_sym", bus.out_sym, hold_sym);
                    check("stall_mask", bus.out_mask, hold_mask);
                end
                check("in_ready_busy", bus.in_ready, 0);
                if (bus.out_ready) begin
                    check($sformatf("sym%0d", n), bus.out_sym, exp_sym[n]);
                    check($sformatf("mask%0d", n), bus.out_mask, exp_mask[n]);
                    check($sformatf("last%0d", n), bus.out_last, exp_last[n]);
                    got_sym[n] = bus.out_sym;
                    $display("sym %0d: out_sym=%b out_mask=%b out_last=%b", n,
                             bus.out_sym, bus.out_mask, bus.out_last);
                    n++;
                    stalled = 0;
                end else begin
                    stalled   = 1;
                    hold_sym  = bus.out_sym;
                    hold_mask = bus.out_mask;
                end
            end else if (stalled) begin
                check("valid_drop", bus.out_valid, 1);
                stalled = 0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 2000) begin
                check("collect_timeout", n, NSYM);
                return;
            end
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("end_out_valid", bus.out_valid, 0);
        check("end_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input string name, input bit p, input int rdy_pct);
        $display("block %s punct=%0d ready=%0d%%", name, p, rdy_pct);
        build_model(p);
        load_block(p);
        collect(rdy_pct, -1);
    endtask

    task automatic fill(input int mode, input int pos);
        for (int i = 0; i < K; i++)
            blk[i] = (mode == 0) ? 1'b0 : (mode == 1) ? (i == pos) : 1'($urandom_range(0, 1));
    endtask

    initial begin
        int diffs;
        int guard;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.punct     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_last", bus.out_last, 0);
        check("reset_out_sym", bus.out_sym, 0);
        check("reset_out_mask", bus.out_mask, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", bus.in_ready, 1);

        fill(0, 0);
        run_block("all_zero", 1'b0, 100);

        fill(1, 0);
        run_block("one_at_0", 1'b0, 100);
        check("idx0_sym0", got_sym[0], 3'b111);

        fill(1, 13);
        run_block("one_at_13", 1'b0, 100);
        check("idx13_sym0_z2", got_sym[0][2], 0);
        check("idx13_sym1_z2", got_sym[1][2], 1);
        check("idx13_sym13_x", got_sym[13][0], 1);

        fill(1, 6);
        run_block("one_at_6", 1'b0, 100);
        check("idx6_sym2_z2", got_sym[2][2], 1);

        fill(2, 0);
        run_block("rand_punct", 1'b1, 100);
        for (int i = 0; i < NSYM; i++) ref_sym[i] = got_sym[i];
        run_block("rand_punct_stall", 1'b1, 50);
        diffs = 0;
        for (int i = 0; i < NSYM; i++) if (got_sym[i] !== ref_sym[i]) diffs++;
        check("stall_replay_diffs", diffs, 0);

        fill(2, 0);
        run_block("rand_rate13_stall", 1'b0, 50);

        fill(2, 0);
        $display("block abort punct=0");
        build_model(1'b0);
        load_block(1'b0);
        collect(100, 20);
        repeat (3) @(posedge clk);
        #1;
        check("abort_hold_valid", bus.out_valid, 0);
        reset = 1'b0;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("abort_in_ready", bus.in_ready, 1);

        fill(2, 0);
        run_block("after_abort", 1'b0, 70);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
